// File: rtl/id_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_stage
// Description : Decode stage. Reads the IF/ID latch and the register file,
//               forwards operands, resolves control transfers and load-use
//               hazards, and registers the ID/EX latch.
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_stage #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Instruction_F,
    input  logic [31:0]       NPC_F,
    output logic [3:0]        rs_addr,
    output logic [3:0]        rt_addr,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    input  logic [3:0]        ex_rd,
    input  logic [3:0]        mem_rd,
    input  logic              ex_regwr,
    input  logic              mem_regwr,
    input  logic              ex_memrd,
    input  logic [31:0]       ex_result,
    input  logic [31:0]       mem_result,
    output logic              disable_PC,
    output logic              disable_IR,
    output logic              KILL,
    output logic [1:0]        PCsrc,
    output logic [31:0]       PC_offset,
    output logic [31:0]       PC_regRs,
    output logic [5:0]        op_E,
    output logic [3:0]        rd_E,
    output logic [31:0]       A_E,
    output logic [31:0]       B_E,
    output logic [31:0]       imm_E,
    output logic [31:0]       NPC_E,
    output logic              regwr_E,
    output logic              memrd_E,
    output logic              memwr_E,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  kill_cnt
);

    localparam logic [5:0] c_OP_ALU_LAST = 6'd4;
    localparam logic [5:0] c_OP_ADDI     = 6'd5;
    localparam logic [5:0] c_OP_LW       = 6'd6;
    localparam logic [5:0] c_OP_SW       = 6'd7;
    localparam logic [5:0] c_OP_BEQ      = 6'd8;
    localparam logic [5:0] c_OP_BNE      = 6'd9;
    localparam logic [5:0] c_OP_J        = 6'd10;
    localparam logic [5:0] c_OP_CALL     = 6'd11;
    localparam logic [5:0] c_OP_JR       = 6'd12;
    localparam logic [3:0] c_LINK_REG    = 4'd15;

    localparam logic [1:0] c_PCSRC_SEQ   = 2'b00;
    localparam logic [1:0] c_PCSRC_OFS   = 2'b01;
    localparam logic [1:0] c_PCSRC_REG   = 2'b10;

    // ------------------------------------------------------------------
    // Field extraction and opcode classification
    // ------------------------------------------------------------------
    logic [5:0]  w_op;
    logic [3:0]  w_rd;
    logic [3:0]  w_rs;
    logic [3:0]  w_rt;
    logic [13:0] w_imm14;
    logic [25:0] w_off26;
    logic [31:0] w_imm_sext;
    logic [31:0] w_off_sext;

    assign w_op       = Instruction_F[31:26];
    assign w_rd       = Instruction_F[25:22];
    assign w_rs       = Instruction_F[21:18];
    assign w_rt       = Instruction_F[17:14];
    assign w_imm14    = Instruction_F[13:0];
    assign w_off26    = Instruction_F[25:0];
    assign w_imm_sext = {{18{w_imm14[13]}}, w_imm14};
    assign w_off_sext = {{6{w_off26[25]}}, w_off26};

    assign rs_addr = w_rs;
    assign rt_addr = w_rt;

    logic w_valid;
    logic w_is_alu;
    logic w_is_addi;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_beq;
    logic w_is_bne;
    logic w_is_j;
    logic w_is_call;
    logic w_is_jr;
    logic w_use_rs;
    logic w_use_rt;
    logic w_writes_reg;

    // The all-zero word would otherwise decode as AND r0,r0,r0; it is a bubble.
    assign w_valid      = (Instruction_F != 32'd0) && (w_op <= c_OP_JR);
    assign w_is_alu     = w_valid && (w_op <= c_OP_ALU_LAST);
    assign w_is_addi    = w_valid && (w_op == c_OP_ADDI);
    assign w_is_lw      = w_valid && (w_op == c_OP_LW);
    assign w_is_sw      = w_valid && (w_op == c_OP_SW);
    assign w_is_beq     = w_valid && (w_op == c_OP_BEQ);
    assign w_is_bne     = w_valid && (w_op == c_OP_BNE);
    assign w_is_j       = w_valid && (w_op == c_OP_J);
    assign w_is_call    = w_valid && (w_op == c_OP_CALL);
    assign w_is_jr      = w_valid && (w_op == c_OP_JR);

    assign w_use_rt     = w_is_alu || w_is_sw || w_is_beq || w_is_bne;
    assign w_use_rs     = w_use_rt || w_is_addi || w_is_lw || w_is_jr;
    assign w_writes_reg = w_is_alu || w_is_addi || w_is_lw || w_is_call;

    // ------------------------------------------------------------------
    // Per-operand bypass network: index 0 = rs, index 1 = rt
    // ------------------------------------------------------------------
    logic [1:0][3:0]  w_src_addr;
    logic [1:0][31:0] w_src_rf;
    logic [1:0][31:0] w_fwd_data;
    logic [1:0]       w_load_hit;

    assign w_src_addr[0] = w_rs;
    assign w_src_addr[1] = w_rt;
    assign w_src_rf[0]   = rs_data;
    assign w_src_rf[1]   = rt_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic w_nonzero;
            logic w_ex_match;
            logic w_ex_hit;
            logic w_mem_hit;

            assign w_nonzero  = (w_src_addr[gi] != 4'd0);
            assign w_ex_match = w_nonzero && ex_regwr && (ex_rd == w_src_addr[gi]);
            // A load in EX has no data yet; it may only be consumed from MEM.
            assign w_ex_hit   = w_ex_match && !ex_memrd;
            assign w_mem_hit  = w_nonzero && mem_regwr && (mem_rd == w_src_addr[gi]);
            assign w_load_hit[gi] = w_ex_match && ex_memrd;

            assign w_fwd_data[gi] = w_ex_hit  ? ex_result  :
                                    w_mem_hit ? mem_result :
                                                w_src_rf[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hazard and control-transfer resolution
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_eq;
    logic w_take_ofs;
    logic w_take_reg;
    logic w_transfer;

    assign w_stall    = (w_use_rs && w_load_hit[0]) || (w_use_rt && w_load_hit[1]);
    assign w_eq       = (w_fwd_data[0] == w_fwd_data[1]);
    assign w_take_ofs = w_is_j || w_is_call || (w_is_beq && w_eq) || (w_is_bne && !w_eq);
    assign w_take_reg = w_is_jr;
    // A branch still waiting on a load must not redirect on stale operands.
    assign w_transfer = !w_stall && (w_take_ofs || w_take_reg);

    always_comb begin
        PCsrc = c_PCSRC_SEQ;
        if (!w_stall) begin
            if (w_take_ofs) begin
                PCsrc = c_PCSRC_OFS;
            end else if (w_take_reg) begin
                PCsrc = c_PCSRC_REG;
            end
        end
    end

    assign disable_PC = w_stall;
    assign disable_IR = w_stall;
    assign KILL       = w_transfer;
    assign PC_offset  = NPC_F + ((w_is_j || w_is_call) ? w_off_sext : w_imm_sext);
    assign PC_regRs   = w_fwd_data[0];

    // ------------------------------------------------------------------
    // ID/EX latch
    // ------------------------------------------------------------------
    logic [5:0]  r_op_e;
    logic [3:0]  r_rd_e;
    logic [31:0] r_a_e;
    logic [31:0] r_b_e;
    logic [31:0] r_imm_e;
    logic [31:0] r_npc_e;
    logic        r_regwr_e;
    logic        r_memrd_e;
    logic        r_memwr_e;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_e    <= 6'd0;
            r_rd_e    <= 4'd0;
            r_a_e     <= 32'd0;
            r_b_e     <= 32'd0;
            r_imm_e   <= 32'd0;
            r_npc_e   <= 32'd0;
            r_regwr_e <= 1'b0;
            r_memrd_e <= 1'b0;
            r_memwr_e <= 1'b0;
        end else if (w_stall || !w_valid) begin
            r_op_e    <= 6'd0;
            r_rd_e    <= 4'd0;
            r_a_e     <= 32'd0;
            r_b_e     <= 32'd0;
            r_imm_e   <= 32'd0;
            r_npc_e   <= 32'd0;
            r_regwr_e <= 1'b0;
            r_memrd_e <= 1'b0;
            r_memwr_e <= 1'b0;
        end else begin
            r_op_e    <= w_op;
            r_rd_e    <= w_is_call ? c_LINK_REG : w_rd;
            r_a_e     <= w_fwd_data[0];
            r_b_e     <= w_fwd_data[1];
            r_imm_e   <= w_imm_sext;
            r_npc_e   <= NPC_F;
            r_regwr_e <= w_writes_reg;
            r_memrd_e <= w_is_lw;
            r_memwr_e <= w_is_sw;
        end
    end

    assign op_E    = r_op_e;
    assign rd_E    = r_rd_e;
    assign A_E     = r_a_e;
    assign B_E     = r_b_e;
    assign imm_E   = r_imm_e;
    assign NPC_E   = r_npc_e;
    assign regwr_E = r_regwr_e;
    assign memrd_E = r_memrd_e;
    assign memwr_E = r_memwr_e;

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_kill_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_kill_cnt  <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_transfer && (r_kill_cnt != '1)) begin
                r_kill_cnt <= r_kill_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign kill_cnt  = r_kill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_hazard_stage
// Description : Self-checking bench for id_hazard_stage with an ID/EX scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_hazard_stage;

    localparam int CNT_W = 3;

    logic              clk;
    logic              reset;
    logic [31:0]       Instruction_F;
    logic [31:0]       NPC_F;
    logic [3:0]        rs_addr;
    logic [3:0]        rt_addr;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [3:0]        ex_rd;
    logic [3:0]        mem_rd;
    logic              ex_regwr;
    logic              mem_regwr;
    logic              ex_memrd;
    logic [31:0]       ex_result;
    logic [31:0]       mem_result;
    logic              disable_PC;
    logic              disable_IR;
    logic              KILL;
    logic [1:0]        PCsrc;
    logic [31:0]       PC_offset;
    logic [31:0]       PC_regRs;
    logic [5:0]        op_E;
    logic [3:0]        rd_E;
    logic [31:0]       A_E;
    logic [31:0]       B_E;
    logic [31:0]       imm_E;
    logic [31:0]       NPC_E;
    logic              regwr_E;
    logic              memrd_E;
    logic              memwr_E;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  kill_cnt;

    id_hazard_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Instruction_F(Instruction_F), .NPC_F(NPC_F),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .ex_rd(ex_rd), .mem_rd(mem_rd),
        .ex_regwr(ex_regwr), .mem_regwr(mem_regwr), .ex_memrd(ex_memrd),
        .ex_result(ex_result), .mem_result(mem_result),
        .disable_PC(disable_PC), .disable_IR(disable_IR), .KILL(KILL),
        .PCsrc(PCsrc), .PC_offset(PC_offset), .PC_regRs(PC_regRs),
        .op_E(op_E), .rd_E(rd_E), .A_E(A_E), .B_E(B_E),
        .imm_E(imm_E), .NPC_E(NPC_E),
        .regwr_E(regwr_E), .memrd_E(memrd_E), .memwr_E(memwr_E),
        .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [3:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
        logic        regwr;
        logic        memrd;
        logic        memwr;
    } idex_t;

    idex_t sb_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic idex_t mk(input logic [5:0] op, input logic [3:0] rd,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [31:0] npc,
                                 input logic regwr, input logic memrd, input logic memwr);
        idex_t e;
        e = '{op, rd, a, b, imm, npc, regwr, memrd, memwr};
        return e;
    endfunction

    function automatic idex_t obs_idex();
        idex_t e;
        e = '{op_E, rd_E, A_E, B_E, imm_E, NPC_E, regwr_E, memrd_E, memwr_E};
        return e;
    endfunction

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt,
                                        input logic [13:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic clr_byp();
        ex_rd = 4'd0; mem_rd = 4'd0;
        ex_regwr = 1'b0; mem_regwr = 1'b0; ex_memrd = 1'b0;
        ex_result = 32'd0; mem_result = 32'd0;
    endtask

    // Expected ID/EX contents are queued with the stimulus and retired after the edge.
    task automatic step(input idex_t exp, input string tag);
        idex_t want;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        chk(tag, obs_idex(), want);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        Instruction_F = 32'd0; NPC_F = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
        clr_byp();
        repeat (2) @(negedge clk);
        chk("rst_idex", obs_idex(), '0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_kill_cnt", kill_cnt, 0);
        chk("rst_disable_pc", disable_PC, 0);
        chk("rst_pcsrc", PCsrc, 0);
        reset = 1'b0;

        // JR r5 with ADD r5 in EX: register redirect through the EX bypass
        ex_rd = 4'd5; ex_regwr = 1'b1; ex_result = 32'h40;
        Instruction_F = enc(6'd12, 4'd0, 4'd5, 4'd0, 14'd0);
        rs_data = 32'h99; rt_data = 32'd0; NPC_F = 32'h30;
        #1;
        chk("jr_pcsrc", PCsrc, 2'b10);
        chk("jr_pc_regrs", PC_regRs, 32'h40);
        chk("jr_kill", KILL, 1);
        chk("jr_disable_pc", disable_PC, 0);
        step(mk(6'd12, 4'd0, 32'h40, 32'd0, 32'd0, 32'h30, 1'b0, 1'b0, 1'b0), "jr_idex");
        chk("jr_kill_cnt", kill_cnt, 1);

        // Load-use stall, then asynchronous reset while still stalled
        clr_byp();
        ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 4'd3; ex_result = 32'hDEAD;
        Instruction_F = enc(6'd1, 4'd4, 4'd3, 4'd2, 14'd0);
        rs_data = 32'h55; rt_data = 32'h22; NPC_F = 32'h11;
        #1;
        chk("stall_disable_pc", disable_PC, 1);
        step('0, "stall_idex");
        chk("stall_cnt_pre_rst", stall_cnt, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_idex", obs_idex(), '0);
        chk("midrst_stall_cnt", stall_cnt, 0);
        chk("midrst_kill_cnt", kill_cnt, 0);
        @(negedge clk);
        Instruction_F = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
        clr_byp();
        reset = 1'b0;
        #1;
        chk("postrst_disable_pc", disable_PC, 0);
        step('0, "postrst_idex");

        // LW r3 in EX, ADD r4,r3,r2 in ID: one stall cycle then MEM forward
        ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 4'd3; ex_result = 32'hDEAD;
        Instruction_F = enc(6'd1, 4'd4, 4'd3, 4'd2, 14'd0);
        rs_data = 32'h55; rt_data = 32'h22; NPC_F = 32'h11;
        #1;
        chk("lu_disable_pc", disable_PC, 1);
        chk("lu_disable_ir", disable_IR, 1);
        chk("lu_kill", KILL, 0);
        chk("lu_pcsrc", PCsrc, 0);
        step('0, "lu_bubble");
        chk("lu_stall_cnt", stall_cnt, 1);
        clr_byp();
        mem_rd = 4'd3; mem_regwr = 1'b1; mem_result = 32'h1234;
        #1;
        chk("lu_release", disable_PC, 0);
        step(mk(6'd1, 4'd4, 32'h1234, 32'h22, 32'd0, 32'h11, 1'b1, 1'b0, 1'b0), "lu_idex");
        chk("lu_stall_cnt_hold", stall_cnt, 1);

        // BEQ r1,r2,-4 taken, then the same compare as BNE (not taken)
        clr_byp();
        Instruction_F = enc(6'd8, 4'd0, 4'd1, 4'd2, 14'h3FFC);
        rs_data = 32'd7; rt_data = 32'd7; NPC_F = 32'h20;
        #1;
        chk("beq_pcsrc", PCsrc, 2'b01);
        chk("beq_pc_offset", PC_offset, 32'h1C);
        chk("beq_kill", KILL, 1);
        step(mk(6'd8, 4'd0, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h20, 1'b0, 1'b0, 1'b0), "beq_idex");
        chk("beq_kill_cnt", kill_cnt, 1);
        Instruction_F = enc(6'd9, 4'd0, 4'd1, 4'd2, 14'h3FFC);
        #1;
        chk("bne_nt_pcsrc", PCsrc, 0);
        chk("bne_nt_kill", KILL, 0);
        step(mk(6'd9, 4'd0, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h20, 1'b0, 1'b0, 1'b0), "bne_nt_idex");

        // Branch waiting on a load: stall wins, no redirect
        ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 4'd1;
        Instruction_F = enc(6'd8, 4'd0, 4'd1, 4'd2, 14'h3FFC);
        #1;
        chk("brload_kill", KILL, 0);
        chk("brload_pcsrc", PCsrc, 0);
        chk("brload_disable_pc", disable_PC, 1);
        step('0, "brload_idex");

        // CALL -1 from NPC 0 wraps; J +5
        clr_byp();
        rs_data = 32'd0; rt_data = 32'd0; NPC_F = 32'd0;
        Instruction_F = {6'd11, 26'h3FF_FFFF};
        #1;
        chk("call_pc_offset", PC_offset, 32'hFFFF_FFFF);
        chk("call_pcsrc", PCsrc, 2'b01);
        chk("call_kill", KILL, 1);
        step(mk(6'd11, 4'd15, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0), "call_idex");
        NPC_F = 32'h100;
        Instruction_F = {6'd10, 26'h5};
        #1;
        chk("j_pc_offset", PC_offset, 32'h105);
        step(mk(6'd10, 4'd0, 32'd0, 32'd0, 32'd5, 32'h100, 1'b0, 1'b0, 1'b0), "j_idex");

        // EX and MEM both write r2: EX has priority, then MEM alone
        ex_rd = 4'd2; ex_regwr = 1'b1; ex_result = 32'hA;
        mem_rd = 4'd2; mem_regwr = 1'b1; mem_result = 32'hB;
        Instruction_F = enc(6'd1, 4'd6, 4'd1, 4'd2, 14'd0);
        rs_data = 32'h11; rt_data = 32'h99; NPC_F = 32'h40;
        step(mk(6'd1, 4'd6, 32'h11, 32'hA, 32'd0, 32'h40, 1'b1, 1'b0, 1'b0), "fwd_ex_prio");
        ex_regwr = 1'b0;
        step(mk(6'd1, 4'd6, 32'h11, 32'hB, 32'd0, 32'h40, 1'b1, 1'b0, 1'b0), "fwd_mem");

        // r0 destinations never forward or stall
        ex_rd = 4'd0; ex_regwr = 1'b1; ex_memrd = 1'b1; ex_result = 32'hAA;
        mem_rd = 4'd0; mem_regwr = 1'b1; mem_result = 32'hBB;
        Instruction_F = enc(6'd1, 4'd6, 4'd1, 4'd0, 14'd0);
        rt_data = 32'd0;
        #1;
        chk("r0_no_stall", disable_PC, 0);
        step(mk(6'd1, 4'd6, 32'h11, 32'd0, 32'd0, 32'h40, 1'b1, 1'b0, 1'b0), "r0_idex");

        // LW and SW control bits, negative SW offset
        clr_byp();
        Instruction_F = enc(6'd6, 4'd7, 4'd1, 4'd0, 14'd3);
        step(mk(6'd6, 4'd7, 32'h11, 32'd0, 32'd3, 32'h40, 1'b1, 1'b1, 1'b0), "lw_idex");
        Instruction_F = enc(6'd7, 4'd0, 4'd1, 4'd2, 14'h2000);
        rt_data = 32'h77;
        step(mk(6'd7, 4'd0, 32'h11, 32'h77, 32'hFFFF_E000, 32'h40, 1'b0, 1'b0, 1'b1), "sw_idex");

        // Undefined opcode is a bubble even with a matching load in EX
        ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 4'd3;
        Instruction_F = enc(6'd13, 4'd1, 4'd3, 4'd3, 14'd0);
        #1;
        chk("bub_no_stall", disable_PC, 0);
        chk("bub_no_kill", KILL, 0);
        step('0, "bub_idex");

        // Kill counter saturation at all-ones
        clr_byp();
        rs_data = 32'd0; rt_data = 32'd0; NPC_F = 32'd0;
        Instruction_F = {6'd10, 26'h0};
        for (int i = 0; i < 5; i++) begin
            step(mk(6'd10, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0), "sat_j_idex");
        end
        chk("kill_cnt_sat", kill_cnt, 3'd7);
        chk("stall_cnt_final", stall_cnt, 3'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
